aes_cbc_ctrl: RTL and testbench
===============================

Name: aes_cbc_ctrl

Overview:
Block-mode sequencer that streams N 128-bit blocks through the shared single-block AES core (start/ready, 10-round iterative) in CBC mode.
- Latches key, IV, direction and block count from a config pulse.
- Accepts blocks on a valid/ready input stream and launches one core operation per block.
- Performs the CBC chaining XOR and returns results on a valid/ready output stream.
- Sits between the bus/DMA front end and the AES core; the core is instantiated alongside it, not inside it.

Parameters:
NBLK_W, 16, width of block-count field (max blocks per job = 2^NBLK_W - 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle job start pulse; ignored while busy=1
cfg_mode  in  1  0 = encrypt, 1 = decrypt
cfg_key  in  128  cipher key
cfg_iv  in  128  initial chaining value
cfg_nblk  in  NBLK_W  number of blocks in job
s_valid  in  1  input block valid
s_ready  out  1  input block accepted when s_valid & s_ready
s_data  in  128  plaintext (enc) or ciphertext (dec)
m_valid  out  1  output block valid
m_ready  in  1  downstream accepts when m_valid & m_ready
m_data  out  128  ciphertext (enc) or plaintext (dec)
aes_start  out  1  core start pulse
aes_mode  out  1  core direction, = latched cfg_mode
aes_key  out  128  core key, = latched cfg_key
aes_in  out  128  core data input
aes_cipher  in  128  core result, valid only in aes_ready cycle
aes_ready  in  1  core one-cycle done pulse
busy  out  1  job in progress
done  out  1  one-cycle pulse after last block handed off

Behaviour:
- Reset values: all outputs 0; state IDLE; chain, key, in/out registers cleared; block counter 0.
- Registers: key_r, mode_r, chain_r, in_r (core input), blk_r (captured s_data), out_r, cnt_r (remaining blocks).
- States:
  - IDLE: on cfg_start, latch cfg_* into key_r/mode_r/chain_r/cnt_r and set busy=1. If cfg_nblk==0, go to DONE; else go to WAIT_IN.
  - WAIT_IN: s_ready=1. On handshake, latch blk_r=s_data and in_r = mode_r ? s_data : s_data^chain_r; go to LAUNCH.
  - LAUNCH: aes_start=1 for exactly one cycle; go to WAIT_CORE.
  - WAIT_CORE: aes_in/aes_key/aes_mode held stable. On aes_ready:
    - Encrypt: out_r = aes_cipher and chain_r = aes_cipher.
    - Decrypt: out_r = aes_cipher^chain_r and chain_r = blk_r.
    - Decrement cnt_r; go to OUTPUT.
  - OUTPUT: m_valid=1 with m_data=out_r, held stable until m_ready. On handshake, if cnt_r==0 go to DONE, else go to WAIT_IN.
  - DONE: done=1 for one cycle, busy=0 next cycle; go to IDLE.
- Stability: aes_in, aes_key and aes_mode must be stable from the cycle before aes_start until aes_ready. The core samples aes_in while idle and uses aes_key throughout.
- Mutual exclusion: s_ready and m_valid are never both high. The design is single-buffered, with one block in flight.
- Latency per block: 1 cycle from s handshake to aes_start, plus core latency, plus 1 cycle from aes_ready to m_valid.
- Unexpected strobes: aes_ready outside WAIT_CORE is ignored. cfg_start while busy is ignored, and the latched config is unchanged.
- Fixed width: the chain XOR is 128-bit bitwise.
- Reset mid-job: all state returns immediately to reset values. The core is reset by the same rst_n.
- Block counter: cnt_r=max (all ones) is a legal count. No wrap occurs, because the counter only decrements and stops at 0.

Decomposition:
- Package aes_pkg holds:
  - state enum (IDLE, WAIT_IN, LAUNCH, WAIT_CORE, OUTPUT, DONE)
  - MODE_ENC=0 / MODE_DEC=1
  - AES_BLK_W=128
- No sub-module: the FSM, XOR and registers fit in one module.
- The AES core connects at the parent level.

Test Plan:
1. Single-block encrypt.
   - Stimulus: key 000102030405060708090a0b0c0d0e0f, IV 0, nblk=1, s_data 00112233445566778899aabbccddeeff.
   - Response: m_data 69c4e0d86a7b0430d8cdb78070b4c55a; done pulses once.
2. Two-block CBC encrypt (SP800-38A F.2.1).
   - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f; P1 6bc1bee22e409f96e93d7e117393172a, P2 ae2d8a571e03ac9c9eb76fac45af8e51.
   - Response: C1 7649abac8119b246cee98e9b12e9197d, then C2 5086cb9b507219ee95db113a917678b2.
3. Two-block CBC decrypt.
   - Stimulus: same key/IV, feed C1 then C2 with mode=1.
   - Response: P1 then P2 exactly; aes_mode=1 throughout.
4. Backpressure and stability.
   - Stimulus: hold m_ready=0 for 20 cycles.
   - Response: m_data stable, s_ready=0, no aes_start; release gives exactly one output handshake.
5. Edge cases.
   - Stimulus: nblk=0, and separately cfg_start while busy.
   - Response: nblk=0 gives done 2 cycles after cfg_start with no aes_start. cfg_start while busy leaves outputs unchanged versus the reference model.
6. Reset during WAIT_CORE.
   - Stimulus: assert rst_n=0 during WAIT_CORE, then release and run a new job.
   - Response: busy, m_valid, aes_start and s_ready drop to 0 asynchronously; the new job gives correct results.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES CBC block-mode sequencer.
package aes_pkg;

  localparam int AES_BLK_W = 128;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IN,
    LAUNCH,
    WAIT_CORE,
    OUTPUT,
    DONE
  } state_t;

endpackage

// File: rtl/aes_cbc_ctrl.sv
// CBC sequencer: streams N blocks through an external single-block AES core,
// applying the chaining XOR on the way in (encrypt) or out (decrypt).
module aes_cbc_ctrl
  import aes_pkg::*;
#(
  parameter int NBLK_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic                 cfg_mode,
  input  logic [AES_BLK_W-1:0] cfg_key,
  input  logic [AES_BLK_W-1:0] cfg_iv,
  input  logic [NBLK_W-1:0]    cfg_nblk,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [AES_BLK_W-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [AES_BLK_W-1:0] m_data,
  output logic                 aes_start,
  output logic                 aes_mode,
  output logic [AES_BLK_W-1:0] aes_key,
  output logic [AES_BLK_W-1:0] aes_in,
  input  logic [AES_BLK_W-1:0] aes_cipher,
  input  logic                 aes_ready,
  output logic                 busy,
  output logic                 done
);

  state_t                 state_r;
  logic [AES_BLK_W-1:0]   key_r;
  logic                   mode_r;
  logic [AES_BLK_W-1:0]   chain_r;
  logic [AES_BLK_W-1:0]   in_r;
  logic [AES_BLK_W-1:0]   blk_r;
  logic [AES_BLK_W-1:0]   out_r;
  logic [NBLK_W-1:0]      cnt_r;
  logic                   s_ready_r;
  logic                   m_valid_r;
  logic                   aes_start_r;
  logic                   busy_r;
  logic                   done_r;

  // Handshake strobes are registered and set on entry to the state that owns
  // them, so each is high for exactly the cycles spent in that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      key_r       <= '0;
      mode_r      <= MODE_ENC;
      chain_r     <= '0;
      in_r        <= '0;
      blk_r       <= '0;
      out_r       <= '0;
      cnt_r       <= '0;
      s_ready_r   <= 1'b0;
      m_valid_r   <= 1'b0;
      aes_start_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      unique case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (cfg_start) begin
            key_r   <= cfg_key;
            mode_r  <= cfg_mode;
            chain_r <= cfg_iv;
            cnt_r   <= cfg_nblk;
            busy_r  <= 1'b1;
            if (cfg_nblk == '0) begin
              state_r <= DONE;
            end else begin
              state_r   <= WAIT_IN;
              s_ready_r <= 1'b1;
            end
          end
        end

        WAIT_IN: begin
          if (s_valid) begin
            blk_r       <= s_data;
            in_r        <= (mode_r == MODE_DEC) ? s_data : (s_data ^ chain_r);
            s_ready_r   <= 1'b0;
            aes_start_r <= 1'b1;
            state_r     <= LAUNCH;
          end
        end

        LAUNCH: begin
          aes_start_r <= 1'b0;
          state_r     <= WAIT_CORE;
        end

        WAIT_CORE: begin
          if (aes_ready) begin
            if (mode_r == MODE_DEC) begin
              out_r   <= aes_cipher ^ chain_r;
              chain_r <= blk_r;
            end else begin
              out_r   <= aes_cipher;
              chain_r <= aes_cipher;
            end
            // Saturating decrement: an all-ones count is a legal job length.
            if (cnt_r != '0) cnt_r <= cnt_r - NBLK_W'(1);
            m_valid_r <= 1'b1;
            state_r   <= OUTPUT;
          end
        end

        OUTPUT: begin
          if (m_ready) begin
            m_valid_r <= 1'b0;
            if (cnt_r == '0) begin
              state_r <= DONE;
            end else begin
              state_r   <= WAIT_IN;
              s_ready_r <= 1'b1;
            end
          end
        end

        DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end

        default: state_r <= IDLE;
      endcase
    end
  end

  // Core-facing signals come straight from registers that only change outside
  // WAIT_CORE, which keeps them stable for the whole core operation.
  assign aes_key   = key_r;
  assign aes_mode  = mode_r;
  assign aes_in    = in_r;
  assign aes_start = aes_start_r;
  assign s_ready   = s_ready_r;
  assign m_valid   = m_valid_r;
  assign m_data    = out_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Bench for aes_cbc_ctrl: behavioural AES core stand-in plus an output scoreboard.
module tb_aes_cbc_ctrl;

  localparam int NBLK_W   = 16;
  localparam int CORE_LAT = 6;
  localparam int TMO      = 200;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_start, cfg_mode;
  logic [127:0]       cfg_key, cfg_iv;
  logic [NBLK_W-1:0]  cfg_nblk;
  logic               s_valid, s_ready;
  logic [127:0]       s_data;
  logic               m_valid, m_ready;
  logic [127:0]       m_data;
  logic               aes_start, aes_mode;
  logic [127:0]       aes_key, aes_in;
  logic               core_ready, spur_ready;
  logic [127:0]       core_cipher, spur_cipher;
  logic               aes_ready_w;
  logic [127:0]       aes_cipher_w;
  logic               busy, done;

  assign aes_ready_w  = core_ready | spur_ready;
  assign aes_cipher_w = spur_ready ? spur_cipher : core_cipher;

  always #5 clk = ~clk;

  aes_cbc_ctrl #(.NBLK_W(NBLK_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_key(cfg_key),
    .cfg_iv(cfg_iv), .cfg_nblk(cfg_nblk),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .aes_start(aes_start), .aes_mode(aes_mode), .aes_key(aes_key),
    .aes_in(aes_in), .aes_cipher(aes_cipher_w), .aes_ready(aes_ready_w),
    .busy(busy), .done(done)
  );

  int errors = 0, checks = 0;
  int starts_cnt = 0, dec_starts = 0, done_cnt = 0, hs_cnt = 0;
  int excl_viol = 0, stab_err = 0;
  logic [127:0] exp_q [$];
  logic [127:0] mon_exp;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Known AES-128 vectors; anything else goes through an invertible stand-in.
  function automatic logic [127:0] core_fn(input logic m, input logic [127:0] k, input logic [127:0] x);
    logic [127:0] tk [3];
    logic [127:0] ti [3];
    logic [127:0] to [3];
    logic [127:0] t;
    tk[0] = 128'h000102030405060708090a0b0c0d0e0f;
    ti[0] = 128'h00112233445566778899aabbccddeeff;
    to[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    tk[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ti[1] = 128'h6bc0bce12a459991e134741a7f9e1925;
    to[1] = 128'h7649abac8119b246cee98e9b12e9197d;
    tk[2] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ti[2] = 128'hd86421fb9f1a1eda505ee1375746972c;
    to[2] = 128'h5086cb9b507219ee95db113a917678b2;
    for (int i = 0; i < 3; i++) begin
      if (!m && k == tk[i] && x == ti[i]) return to[i];
      if (m && k == tk[i] && x == to[i]) return ti[i];
    end
    if (!m) return {x[119:0], x[127:120]} ^ k;
    t = x ^ k;
    return {t[7:0], t[127:8]};
  endfunction

  // Behavioural core: samples on aes_start, answers CORE_LAT cycles later.
  logic [127:0] c_in, c_key;
  logic         c_mode, c_abort;
  initial begin
    core_ready = 1'b0;
    core_cipher = '0;
    forever begin
      @(negedge clk);
      if (aes_start && rst_n) begin
        c_in = aes_in; c_key = aes_key; c_mode = aes_mode; c_abort = 1'b0;
        if (c_mode) dec_starts++;
        for (int i = 0; i < CORE_LAT; i++) begin
          @(negedge clk);
          if (!rst_n) c_abort = 1'b1;
          else if (!c_abort && (aes_in !== c_in || aes_key !== c_key || aes_mode !== c_mode))
            stab_err++;
        end
        if (!c_abort && rst_n) begin
          core_ready = 1'b1;
          core_cipher = core_fn(c_mode, c_key, c_in);
          @(negedge clk);
          core_ready = 1'b0;
        end
      end
    end
  end

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (aes_start) starts_cnt++;
      if (done) done_cnt++;
      if (s_ready && m_valid) excl_viol++;
      if (m_valid && m_ready) begin
        hs_cnt++;
        $display("out %0d: m_data=%h mode=%0d", hs_cnt, m_data, aes_mode);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m_data: got %h expected no output", m_data);
        end else begin
          mon_exp = exp_q.pop_front();
          chk($sformatf("m_data[%0d]", hs_cnt), m_data, mon_exp);
        end
      end
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic cfg(input logic mode, input logic [127:0] key, input logic [127:0] iv,
                     input logic [NBLK_W-1:0] nblk);
    cfg_mode = mode; cfg_key = key; cfg_iv = iv; cfg_nblk = nblk; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send(input logic [127:0] d);
    int n = 0;
    s_valid = 1'b1; s_data = d;
    while (!s_ready && n < TMO) begin @(posedge clk); #1; n++; end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL s_handshake: got timeout expected s_ready");
    end else begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < TMO) begin @(posedge clk); #1; n++; end
    chk("done_seen", {127'd0, done}, 128'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] k, input logic [127:0] p, input logic [127:0] ch);
    logic [127:0] x;
    x = p ^ ch;
    return {x[119:0], x[127:120]} ^ k;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] k, input logic [127:0] c, input logic [127:0] ch);
    logic [127:0] t;
    t = c ^ k;
    return {t[7:0], t[127:8]} ^ ch;
  endfunction

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] C2 = 128'h5086cb9b507219ee95db113a917678b2;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, s0, h0, ds0, n, bp_err;
    logic [127:0] kb, ivb, b1, b2, e1, e2, hold, ch;

    rst_n = 1'b0; cfg_start = 1'b0; cfg_mode = 1'b0; cfg_key = '0; cfg_iv = '0;
    cfg_nblk = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    spur_ready = 1'b0; spur_cipher = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_outs", {124'd0, m_valid, s_ready, aes_start, done}, 128'd0);
    chk("rst_m_data", m_data, 128'd0);
    chk("rst_aes_key", aes_key, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single-block encrypt (FIPS-197 C.1)
    d0 = done_cnt;
    cfg(1'b0, K1, 128'd0, 16'd1);
    exp_q.push_back(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    send(128'h00112233445566778899aabbccddeeff);
    wait_done();
    chk("t1_done_cnt", 128'(done_cnt - d0), 128'd1);

    // 2: two-block CBC encrypt
    cfg(1'b0, K2, IV2, 16'd2);
    exp_q.push_back(C1); send(P1);
    exp_q.push_back(C2); send(P2);
    wait_done();

    // 3: two-block CBC decrypt
    ds0 = dec_starts; s0 = starts_cnt;
    cfg(1'b1, K2, IV2, 16'd2);
    chk("t3_aes_mode", {127'd0, aes_mode}, 128'd1);
    exp_q.push_back(P1); send(C1);
    exp_q.push_back(P2); send(C2);
    wait_done();
    chk("t3_dec_starts", 128'(dec_starts - ds0), 128'd2);
    chk("t3_starts", 128'(starts_cnt - s0), 128'd2);

    // 4: backpressure, with a stray aes_ready while the output is held
    kb = 128'hfedcba98765432100123456789abcdef; ivb = 128'h0f0e0d0c0b0a09080706050403020100;
    b1 = 128'h11111111222222223333333344444444; b2 = 128'hdeadbeefcafef00d0123456789abcdef;
    e1 = ref_enc(kb, b1, ivb); e2 = ref_enc(kb, b2, e1);
    m_ready = 1'b0;
    cfg(1'b0, kb, ivb, 16'd2);
    exp_q.push_back(e1); send(b1);
    n = 0;
    while (!m_valid && n < TMO) begin @(posedge clk); #1; n++; end
    chk("t4_m_valid", {127'd0, m_valid}, 128'd1);
    chk("t4_m_data", m_data, e1);
    hold = m_data; s0 = starts_cnt; bp_err = 0;
    for (int i = 0; i < 20; i++) begin
      spur_ready = (i == 5); spur_cipher = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
      @(posedge clk); #1;
      spur_ready = 1'b0;
      if (m_data !== hold || s_ready !== 1'b0 || m_valid !== 1'b1) bp_err++;
    end
    chk("t4_hold_stable", 128'(bp_err), 128'd0);
    chk("t4_no_start", 128'(starts_cnt - s0), 128'd0);
    h0 = hs_cnt;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_one_hs", 128'(hs_cnt - h0), 128'd1);
    exp_q.push_back(e2); send(b2);
    m_ready = 1'b1;
    wait_done();

    // 5a: zero-block job
    s0 = starts_cnt;
    cfg(1'b0, kb, ivb, 16'd0);
    chk("t5_busy", {127'd0, busy}, 128'd1);
    chk("t5_done_early", {127'd0, done}, 128'd0);
    @(posedge clk); #1;
    chk("t5_done", {127'd0, done}, 128'd1);
    chk("t5_busy_clr", {127'd0, busy}, 128'd0);
    chk("t5_no_start", 128'(starts_cnt - s0), 128'd0);
    @(posedge clk); #1;

    // 5b: cfg_start while busy is ignored
    b1 = 128'h0123456789abcdeffedcba9876543210;
    cfg(1'b0, K1, ivb, 16'd1);
    cfg(1'b1, kb, 128'd0, 16'd5);
    chk("t5_key_kept", aes_key, K1);
    chk("t5_mode_kept", {127'd0, aes_mode}, 128'd0);
    exp_q.push_back(ref_enc(K1, b1, ivb)); send(b1);
    wait_done();

    // 6: reset while the core is working, then a fresh decrypt job
    cfg(1'b0, kb, ivb, 16'd2);
    send(b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", {127'd0, busy}, 128'd0);
    chk("t6_strobes", {125'd0, m_valid, aes_start, s_ready}, 128'd0);
    chk("t6_aes_in", aes_in, 128'd0);
    repeat (CORE_LAT + 2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    kb = 128'hc0ffee00112233445566778899aabbcc; ivb = 128'h00000000ffffffff00000000ffffffff;
    b1 = 128'h0badf00d0badf00d0badf00d0badf00d; b2 = 128'h13579bdf2468ace013579bdf2468ace0;
    ch = ivb;
    d0 = done_cnt;
    cfg(1'b1, kb, ivb, 16'd2);
    exp_q.push_back(ref_dec(kb, b1, ch)); ch = b1; send(b1);
    exp_q.push_back(ref_dec(kb, b2, ch)); send(b2);
    wait_done();
    chk("t6_done_cnt", 128'(done_cnt - d0), 128'd1);

    repeat (3) @(posedge clk);
    chk("sb_empty", 128'(exp_q.size()), 128'd0);
    chk("excl_viol", 128'(excl_viol), 128'd0);
    chk("core_in_stable", 128'(stab_err), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
